// File: rtl/ext_mem_seq_pkg.sv
// Shared types and constants for the external memory sequencer: command opcodes,
// FSM states and the legal range of DRAM read latency.
package ext_mem_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_IRAM = 2'd0,
        OP_LOAD_DRAM = 2'd1,
        OP_RUN       = 2'd2,
        OP_READ_DRAM = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HOLD
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Out-of-range latency parameters are pulled back into the supported window.
    function automatic int clamp_rd_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/ext_mem_seq_run_timer.sv
// Cycle counter bounding how long the processor may run; expired flags the cycle
// whose increment would reach TIMEOUT.
module ext_mem_seq_run_timer #(
    parameter int TIMEOUT = 200000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ext_mem_sequencer.sv
// Host-side sequencer: loads IRAMs/DRAM, runs the multicore processor to completion
// or timeout, and streams DRAM words back out, one transaction at a time.
module ext_mem_sequencer
    import ext_mem_seq_pkg::*;
#(
    parameter int NUM_CORES   = 2,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 1,
    parameter int RUN_TIMEOUT = 200000,
    parameter int CORE_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CORE_W-1:0]    cmd_core,
    input  logic [ADDR_W-1:0]    cmd_base,
    input  logic [ADDR_W-1:0]    cmd_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [ADDR_W-1:0]    addr_ext,
    output logic [DATA_W-1:0]    data_ext,
    output logic [NUM_CORES-1:0] iram_write_ext,
    output logic                 dram_write_ext,
    output logic                 read_en_ext,
    input  logic [DATA_W-1:0]    dram_rdata,
    output logic                 start,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 busy,
    output logic                 run_done,
    output logic                 err
);

    localparam int         LAT      = clamp_rd_lat(RD_LAT);
    localparam logic [1:0] WAIT_END = 2'(LAT - 1);

    state_e                state;
    op_e                   op_q;
    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W-1:0]     len_q;
    logic [ADDR_W-1:0]     idx;
    logic [NUM_CORES-1:0]  core_mask;
    logic [1:0]            wait_cnt;
    logic                  drain;
    logic                  timer_expired;

    wire accept   = cmd_valid && cmd_ready;
    wire in_fire  = in_valid && in_ready;
    wire out_fire = out_valid && out_ready;
    wire core_ok  = int'(cmd_core) < NUM_CORES;
    wire last_idx = (idx == len_q - ADDR_W'(1));

    assign busy = (state != ST_IDLE);

    function automatic logic [NUM_CORES-1:0] core_onehot(input logic [CORE_W-1:0] c);
        logic [NUM_CORES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CORES; i++) m[i] = (int'(c) == i);
        return m;
    endfunction

    ext_mem_seq_run_timer #(.TIMEOUT(RUN_TIMEOUT)) u_run_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .enable  (state == ST_RUN),
        .expired (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            op_q           <= OP_LOAD_IRAM;
            base_q         <= '0;
            len_q          <= '0;
            idx            <= '0;
            core_mask      <= '0;
            wait_cnt       <= '0;
            drain          <= 1'b0;
            cmd_ready      <= 1'b1;
            in_ready       <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            addr_ext       <= '0;
            data_ext       <= '0;
            iram_write_ext <= '0;
            dram_write_ext <= 1'b0;
            read_en_ext    <= 1'b0;
            start          <= 1'b0;
            run_done       <= 1'b0;
            err            <= 1'b0;
        end else begin
            // NOTE: one-cycle strobes default low here with <=; a later <= in the same pass wins.
            iram_write_ext <= '0;
            dram_write_ext <= 1'b0;
            read_en_ext    <= 1'b0;
            run_done       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= op_e'(cmd_op);
                        base_q    <= cmd_base;
                        len_q     <= cmd_len;
                        idx       <= '0;
                        core_mask <= core_onehot(cmd_core);
                        if (op_e'(cmd_op) == OP_LOAD_IRAM && !core_ok) begin
                            err <= 1'b1;
                        end else if (op_e'(cmd_op) == OP_RUN) begin
                            state     <= ST_RUN;
                            start     <= 1'b1;
                            cmd_ready <= 1'b0;
                        end else if (cmd_len == '0) begin
                            // Empty transfers park one cycle in LOAD with in_ready low.
                            state     <= ST_LOAD;
                            drain     <= 1'b1;
                            cmd_ready <= 1'b0;
                        end else if (op_e'(cmd_op) == OP_READ_DRAM) begin
                            state       <= ST_RD_ISSUE;
                            read_en_ext <= 1'b1;
                            addr_ext    <= cmd_base;
                            cmd_ready   <= 1'b0;
                        end else begin
                            state     <= ST_LOAD;
                            in_ready  <= 1'b1;
                            cmd_ready <= 1'b0;
                        end
                    end
                end

                ST_LOAD: begin
                    if (drain) begin
                        drain     <= 1'b0;
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end else if (in_fire) begin
                        addr_ext <= base_q + idx;
                        data_ext <= in_data;
                        if (op_q == OP_LOAD_IRAM) iram_write_ext <= core_mask;
                        else                      dram_write_ext <= 1'b1;
                        idx <= idx + ADDR_W'(1);
                        if (last_idx) begin
                            in_ready <= 1'b0;
                            drain    <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    // Completion is checked first so a coincident timeout still counts as done.
                    if (&core_done) begin
                        start     <= 1'b0;
                        run_done  <= 1'b1;
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end else if (timer_expired) begin
                        start     <= 1'b0;
                        err       <= 1'b1;
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end

                ST_RD_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    if (wait_cnt == WAIT_END) begin
                        out_data  <= dram_rdata;
                        out_valid <= 1'b1;
                        state     <= ST_RD_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                ST_RD_HOLD: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        if (last_idx) begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                        end else begin
                            idx         <= idx + ADDR_W'(1);
                            addr_ext    <= base_q + idx + ADDR_W'(1);
                            read_en_ext <= 1'b1;
                            state       <= ST_RD_ISSUE;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_sequencer.sv
// Directed self-checking bench for ext_mem_sequencer: loads, wrap, bad core, run/timeout,
// stalled readback and mid-command reset.
module tb_ext_mem_sequencer;

    localparam int NUM_CORES   = 2;
    localparam int CORE_W      = 2;
    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 16;
    localparam int RD_LAT      = 1;
    localparam int RUN_TIMEOUT = 100;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_op = '0;
    logic [CORE_W-1:0]    cmd_core = '0;
    logic [ADDR_W-1:0]    cmd_base = '0;
    logic [ADDR_W-1:0]    cmd_len = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DATA_W-1:0]    out_data;
    logic [ADDR_W-1:0]    addr_ext;
    logic [DATA_W-1:0]    data_ext;
    logic [NUM_CORES-1:0] iram_write_ext;
    logic                 dram_write_ext;
    logic                 read_en_ext;
    logic [DATA_W-1:0]    dram_rdata = '0;
    logic                 start;
    logic [NUM_CORES-1:0] core_done = '0;
    logic                 busy;
    logic                 run_done;
    logic                 err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_CORES-1:0] iram;
        logic                 dram;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
        int                   cyc;
    } wr_t;

    wr_t               wr_q[$];
    logic [ADDR_W-1:0] rd_addr_q[$];
    int                cyc = 0;
    int                rd_pulses = 0;
    int                start_cycles = 0;
    int                run_done_cnt = 0;
    int                viol = 0;
    logic              rd_prev = 1'b0;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    ext_mem_sequencer #(
        .NUM_CORES(NUM_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RD_LAT(RD_LAT), .RUN_TIMEOUT(RUN_TIMEOUT), .CORE_W(CORE_W)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_core(cmd_core),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .addr_ext(addr_ext), .data_ext(data_ext), .iram_write_ext(iram_write_ext),
        .dram_write_ext(dram_write_ext), .read_en_ext(read_en_ext), .dram_rdata(dram_rdata),
        .start(start), .core_done(core_done), .busy(busy), .run_done(run_done), .err(err)
    );

    always #5 clock = ~clock;

    // DRAM model with one-cycle read latency; non-read cycles return a poison value.
    always @(posedge clock) begin
        if (read_en_ext === 1'b1) dram_rdata <= mem[addr_ext];
        else                      dram_rdata <= 16'hDEAD;
    end

    always @(negedge clock) begin
        cyc++;
        if ((|iram_write_ext) === 1'b1 || dram_write_ext === 1'b1)
            wr_q.push_back('{iram_write_ext, dram_write_ext, addr_ext, data_ext, cyc});
        if (read_en_ext === 1'b1) begin
            rd_pulses++;
            rd_addr_q.push_back(addr_ext);
            if (rd_prev) viol++;
        end
        rd_prev = (read_en_ext === 1'b1);
        if ($countones({iram_write_ext, dram_write_ext, read_en_ext}) > 1) viol++;
        if (start === 1'b1 && busy !== 1'b1) viol++;
        if (start === 1'b1) start_cycles++;
        if (run_done === 1'b1) run_done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers a command once cmd_ready is seen; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [CORE_W-1:0] core,
                            input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (cmd_ready !== 1'b1) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_core  = core;
        cmd_base  = base;
        cmd_len   = len;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_out_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (out_valid !== 1'b1) check(tag, 32'(out_valid), 32'd1);
    endtask

    initial begin
        mem[5] = 16'h1234;
        mem[6] = 16'hBEEF;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_outputs", {23'd0, busy, in_ready, out_valid, start, run_done, err,
                              dram_write_ext, read_en_ext, |iram_write_ext}, 32'd0);
        check("rst_addr", 32'(addr_ext), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // LOAD_IRAM core 1, base 1, three back-to-back words
        wr_q.delete();
        send_cmd(2'd0, 2'd1, 9'd1, 9'd3);
        check("li_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 16'd10;
        @(negedge clock); in_data = 16'd20;
        @(negedge clock); in_data = 16'd30;
        @(negedge clock); in_valid = 1'b0;
        check("li_in_ready_drop", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clock);
        check("li_count", 32'(wr_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("li_strobe%0d", i), {29'd0, wr_q[i].dram, wr_q[i].iram}, 32'b010);
            check($sformatf("li_addr%0d", i), 32'(wr_q[i].addr), 32'(i + 1));
            check($sformatf("li_data%0d", i), 32'(wr_q[i].data), 32'((i + 1) * 10));
        end
        check("li_back_to_back", 32'(wr_q[2].cyc - wr_q[0].cyc), 32'd2);
        check("li_idle", 32'(busy), 32'd0);

        // LOAD_DRAM base 511 wraps to 0; busy falls the cycle after the last write
        wr_q.delete();
        send_cmd(2'd1, 2'd0, 9'd511, 9'd2);
        in_valid = 1'b1; in_data = 16'd7;
        @(negedge clock); in_data = 16'd8;
        @(negedge clock); in_valid = 1'b0;
        check("ld_last_write_seen", 32'(dram_write_ext), 32'd1);
        check("ld_busy_on_last", 32'(busy), 32'd1);
        @(negedge clock);
        check("ld_busy_after", 32'(busy), 32'd0);
        check("ld_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("ld_count", 32'(wr_q.size()), 32'd2);
        check("ld_w0", {wr_q[0].iram, wr_q[0].dram, wr_q[0].addr, wr_q[0].data},
              {2'b00, 1'b1, 9'd511, 16'd7});
        check("ld_w1", {wr_q[1].iram, wr_q[1].dram, wr_q[1].addr, wr_q[1].data},
              {2'b00, 1'b1, 9'd0, 16'd8});

        // Zero-length load: one busy cycle, no strobes
        wr_q.delete();
        send_cmd(2'd1, 2'd0, 9'd40, 9'd0);
        check("z_busy", {30'd0, busy, in_ready}, 32'b10);
        @(negedge clock);
        check("z_idle", {30'd0, busy, cmd_ready}, 32'b01);
        check("z_no_writes", 32'(wr_q.size()), 32'd0);

        // RUN completes once all cores report done
        start_cycles = 0; run_done_cnt = 0;
        send_cmd(2'd2, 2'd0, 9'd0, 9'd0);
        check("run_start", 32'(start), 32'd1);
        repeat (20) @(negedge clock);
        core_done = 2'b01;
        repeat (30) @(negedge clock);
        core_done = 2'b11;
        @(negedge clock);
        check("run_start_drop", 32'(start), 32'd0);
        check("run_done_pulse", 32'(run_done), 32'd1);
        @(negedge clock);
        core_done = 2'b00;
        check("run_done_single", 32'(run_done_cnt), 32'd1);
        check("run_start_cycles", 32'(start_cycles), 32'd51);
        check("run_no_err", 32'(err), 32'd0);
        check("run_idle", 32'(busy), 32'd0);

        // RUN timeout with cores never done
        start_cycles = 0; run_done_cnt = 0;
        send_cmd(2'd2, 2'd0, 9'd0, 9'd0);
        for (int i = 0; i < 150 && start === 1'b1; i++) @(negedge clock);
        check("to_start_drop", 32'(start), 32'd0);
        check("to_start_cycles", 32'(start_cycles), 32'(RUN_TIMEOUT));
        check("to_err", 32'(err), 32'd1);
        check("to_no_run_done", 32'(run_done_cnt), 32'd0);
        check("to_idle", 32'(busy), 32'd0);

        do_reset();
        check("rst_clears_err", 32'(err), 32'd0);

        // Bad core index: error, command dropped, stays idle
        wr_q.delete();
        send_cmd(2'd0, 2'd2, 9'd0, 9'd4);
        check("bc_err", 32'(err), 32'd1);
        check("bc_idle", {30'd0, busy, cmd_ready}, 32'b01);
        repeat (3) @(negedge clock);
        check("bc_no_writes", 32'(wr_q.size()), 32'd0);

        // READ_DRAM base 5, len 2, stalled readback
        rd_pulses = 0; rd_addr_q.delete();
        send_cmd(2'd3, 2'd0, 9'd5, 9'd2);
        wait_out_valid("rd0_valid_timeout");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd0_stall%0d", i), {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h1234});
            if (i < 2) @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("rd0_released", 32'(out_valid), 32'd0);
        wait_out_valid("rd1_valid_timeout");
        check("rd1_data", 32'(out_data), 32'h0000BEEF);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("rd_end", {29'd0, out_valid, busy, cmd_ready}, 32'b001);
        check("rd_pulses", 32'(rd_pulses), 32'd2);
        check("rd_addrs", {rd_addr_q[0], rd_addr_q[1]}, {9'd5, 9'd6});
        check("rd_err_sticky", 32'(err), 32'd1);

        do_reset();
        check("rst_clears_err2", 32'(err), 32'd0);

        // Reset during the second word of a load
        wr_q.delete();
        send_cmd(2'd1, 2'd0, 9'd20, 9'd4);
        in_valid = 1'b1; in_data = 16'hAAAA;
        @(negedge clock);
        in_data = 16'hBBBB;
        reset = 1'b1;
        @(negedge clock);
        check("mr_strobes", {29'd0, |iram_write_ext, dram_write_ext, read_en_ext}, 32'd0);
        check("mr_state", {29'd0, busy, cmd_ready, in_ready}, 32'b010);
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("mr_one_write", 32'(wr_q.size()), 32'd1);
        check("mr_first_word", {wr_q[0].addr, wr_q[0].data}, {9'd20, 16'hAAAA});

        check("strobe_invariants", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
